// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART-driven APB initiator.
// Contents:
//   CMD_WRITE / CMD_READ   - command bytes accepted from the host
//   RSP_OK / RSP_ERR / RSP_TMO - single-byte status responses
//   state_t                - bridge FSM states
package uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/apb_uart_master_if.sv
// APB bus bundle between the bridge core and the outside world.
// Signals: PADDR, PWDATA, PWRITE, PSEL, PENABLE (initiator -> target),
//          PRDATA, PREADY (target -> initiator).
// Modports: master (initiator side), slave (target side).
interface apb_uart_master_if;

  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_uart_master_core.sv
// Bridge FSM: parses host command frames, runs one APB transfer, queues
// the response bytes for the UART transmitter.
// Ports:
//   clk, rst_i          - clock, synchronous active-high reset
//   rx_data/rx_valid/rx_perr - received byte stream
//   tx_data/tx_valid    - response byte offered to the transmitter
//   tx_done             - transmitter finished the offered byte
//   busy                - FSM not idle
//   apb                 - APB initiator side
module apb_uart_master_core
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_perr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_done,
  output logic       busy,
  apb_uart_master_if.master apb
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rsp_q, rsp_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] tmo_q, tmo_d;
  logic        psel, penable;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rsp_q   <= '0;
      last_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rsp_q   <= rsp_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rsp_d   = rsp_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    psel    = 1'b0;
    penable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cnt_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          if (!rx_perr && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            write_d = (rx_data == CMD_WRITE);
            state_d = ST_ADDR;
          end else begin
            rsp_d   = {24'h0, RSP_ERR};
            last_d  = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (rx_valid) begin
          if (rx_perr) begin
            cnt_d   = '0;
            rsp_d   = {24'h0, RSP_ERR};
            last_d  = '0;
            state_d = ST_RESP;
          end else begin
            if (state_q == ST_ADDR) addr_d  = addr_q  | (32'(rx_data) << {cnt_q, 3'b000});
            else                    wdata_d = wdata_q | (32'(rx_data) << {cnt_q, 3'b000});
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (state_q == ST_ADDR && write_q) state_d = ST_WDATA;
              else                               state_d = ST_SETUP;
            end
          end
        end
      end
      ST_SETUP: begin
        psel    = 1'b1;
        tmo_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        cnt_d   = '0;
        if (apb.PREADY) begin
          rsp_d   = write_q ? {24'h0, RSP_OK} : apb.PRDATA;
          last_d  = write_q ? 2'd0 : 2'd3;
          state_d = ST_RESP;
        end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          rsp_d   = {24'h0, RSP_TMO};
          last_d  = '0;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_RESP: begin
        if (tx_done) begin
          if (cnt_q == last_q) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign apb.PADDR   = addr_q;
  assign apb.PWDATA  = wdata_q;
  assign apb.PWRITE  = write_q;
  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign busy        = (state_q != ST_IDLE);
  assign tx_valid    = (state_q == ST_RESP);
  assign tx_data     = rsp_q[{cnt_q, 3'b000} +: 8];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), even parity, 1 stop.
// Ports:
//   clk        - clock
//   rstn_i     - synchronous active-low reset
//   clk_div_i  - clock cycles per bit
//   rx_i       - serial input (idle high)
//   data_o     - received byte, valid with valid_o
//   valid_o    - one-cycle pulse per received frame
//   perr_o     - parity mismatch flag for the frame flagged by valid_o
module uart_rx (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [31:0] clk_div_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        perr_o
);

  logic [1:0]  sync_q;
  logic        active_q;
  logic [31:0] cnt_q;
  logic [3:0]  nbit_q;
  logic [8:0]  sh_q;
  logic [31:0] tgt;

  // Bit 0 is the start-bit check at mid-bit; later bits sample one period apart.
  always_comb begin
    tgt = (nbit_q == 4'd0) ? (clk_div_i >> 1) : (clk_div_i - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      sync_q   <= '1;
      active_q <= 1'b0;
      cnt_q    <= '0;
      nbit_q   <= '0;
      sh_q     <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      perr_o   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      valid_o <= 1'b0;
      if (!active_q) begin
        if (!sync_q[1]) begin
          active_q <= 1'b1;
          cnt_q    <= '0;
          nbit_q   <= '0;
        end
      end else if (cnt_q == tgt) begin
        cnt_q <= '0;
        if (nbit_q == 4'd0) begin
          if (sync_q[1]) active_q <= 1'b0;
          else           nbit_q   <= 4'd1;
        end else if (nbit_q == 4'd10) begin
          // Stop-bit slot: sh_q holds {parity, data}.
          active_q <= 1'b0;
          valid_o  <= 1'b1;
          data_o   <= sh_q[7:0];
          perr_o   <= ^sh_q;
        end else begin
          sh_q   <= {sync_q[1], sh_q[8:1]};
          nbit_q <= nbit_q + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 8 data (LSB first), even parity, 1 stop.
// Ports:
//   clk        - clock
//   rstn_i     - synchronous active-low reset
//   clk_div_i  - clock cycles per bit
//   data_i     - byte to send, sampled when a frame starts
//   valid_i    - request; a frame starts while idle and valid_i is high
//   done_o     - one-cycle pulse after the stop bit
//   tx_o       - serial output (idle high)
module uart_tx (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [31:0] clk_div_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        done_o,
  output logic        tx_o
);

  logic [10:0] sh_q;
  logic [31:0] cnt_q;
  logic [3:0]  nbit_q;
  logic        active_q;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      sh_q     <= '1;
      cnt_q    <= '0;
      nbit_q   <= '0;
      active_q <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!active_q) begin
        // Skip the cycle of done_o so the requester can retire the byte
        // before it is picked up a second time.
        if (valid_i && !done_o) begin
          sh_q     <= {1'b1, ^data_i, data_i, 1'b0};
          cnt_q    <= '0;
          nbit_q   <= '0;
          active_q <= 1'b1;
        end
      end else if (cnt_q == clk_div_i - 32'd1) begin
        cnt_q <= '0;
        sh_q  <= {1'b1, sh_q[10:1]};
        if (nbit_q == 4'd10) begin
          active_q <= 1'b0;
          done_o   <= 1'b1;
        end else begin
          nbit_q <= nbit_q + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign tx_o = sh_q[0];

endmodule

// File: rtl/apb_uart_master.sv
// UART-commanded APB initiator (top level).
// Ports:
//   clk, rst_i    - clock, synchronous active-high reset
//   rx_i, tx_o    - host serial command / response lines
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE - APB initiator outputs
//   PRDATA, PREADY - APB target inputs
//   busy_o        - bridge FSM not idle
module apb_uart_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] CLK_DIV_RST    = 32'd868
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy_o
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_done;

  apb_uart_master_if apb ();

  uart_rx u_rx (
    .clk       (clk),
    .rstn_i    (~rst_i),
    .clk_div_i (CLK_DIV_RST),
    .rx_i      (rx_i),
    .data_o    (rx_data),
    .valid_o   (rx_valid),
    .perr_o    (rx_perr)
  );

  uart_tx u_tx (
    .clk       (clk),
    .rstn_i    (~rst_i),
    .clk_div_i (CLK_DIV_RST),
    .data_i    (tx_data),
    .valid_i   (tx_valid),
    .done_o    (tx_done),
    .tx_o      (tx_o)
  );

  apb_uart_master_core #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_core (
    .clk      (clk),
    .rst_i    (rst_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_perr  (rx_perr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_done  (tx_done),
    .busy     (busy_o),
    .apb      (apb)
  );

  assign PADDR      = apb.PADDR;
  assign PWDATA     = apb.PWDATA;
  assign PWRITE     = apb.PWRITE;
  assign PSEL       = apb.PSEL;
  assign PENABLE    = apb.PENABLE;
  assign apb.PRDATA = PRDATA;
  assign apb.PREADY = PREADY;

endmodule

// File: doc/apb_uart_master.md
APB_UART_MASTER -- requirements
Module: apb_uart_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum ACCESS-phase cycles before abort.
REQ-002 SHALL have parameter CLK_DIV_RST, default 32'd868: clock-divider value passed to the serial sub-modules.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_i, input, 1: serial command line from host.
REQ-006 SHALL have port tx_o, output, 1: serial response line to host.
REQ-007 SHALL have port PADDR, output, 32: APB address.
REQ-008 SHALL have port PWDATA, output, 32: APB write data.
REQ-009 SHALL have port PWRITE, output, 1: APB direction.
REQ-010 SHALL have port PSEL, output, 1: APB select.
REQ-011 SHALL have port PENABLE, output, 1: APB enable.
REQ-012 SHALL have port PRDATA, input, 32: APB read data.
REQ-013 SHALL have port PREADY, input, 1: APB ready.
REQ-014 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL act as APB initiator driven by a byte protocol over UART: command byte, 4 address bytes LSB first, then 4 data bytes LSB first for writes only.
REQ-016 SHALL use command bytes 0x57 (write) and 0x52 (read); any other command byte in IDLE SHALL be dropped and answered with 0x45.
REQ-017 SHALL implement states IDLE, ADDR, WDATA, SETUP, ACCESS, RESP.
REQ-018 SHALL use a 2-bit byte counter: ADDR exits after 4 bytes, to WDATA (write) or SETUP (read); WDATA exits to SETUP after 4 bytes.
REQ-019 SHALL assemble bytes as reg |= byte << (8*cnt); the counter wraps to 0 on each phase exit.
REQ-020 SHALL, in SETUP, drive PSEL=1 and PENABLE=0 for exactly one cycle, with PADDR/PWDATA/PWRITE stable.
REQ-021 SHALL, in ACCESS, drive PSEL=1 and PENABLE=1 until PREADY=1; PADDR/PWDATA/PWRITE SHALL stay stable.
REQ-022 SHALL, on the PREADY=1 cycle of a read, capture PRDATA and enter RESP the next cycle.
REQ-023 SHALL, when ACCESS lasts TIMEOUT_CYCLES cycles without PREADY, deassert PSEL/PENABLE and respond 0x54.
REQ-024 SHALL send responses in RESP: write gives 0x4B (1 byte); read gives 4 data bytes LSB first; errors give 1 byte.
REQ-025 SHALL hold tx_valid with a stable byte until the uart_tx done pulse, then advance to the next byte; after the last byte it SHALL return to IDLE.
REQ-026 SHALL, on an RX parity error during ADDR/WDATA, abort the frame, issue no APB transfer and respond 0x45.
REQ-027 SHALL discard received bytes while in SETUP/ACCESS/RESP.
REQ-028 SHALL hold PSEL=0 and PENABLE=0 in all states other than SETUP/ACCESS.

Reset
REQ-029 SHALL, with rst_i high at a clock edge, clear state to IDLE, zero the counters, address and data registers, and set PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy_o=0, tx_o=1.
REQ-030 SHALL, when reset is asserted mid-transfer (including during ACCESS), drop PSEL the next cycle and emit no response.

Structure
REQ-031 SHALL take command/response byte constants (0x57, 0x52, 0x4B, 0x45, 0x54) and the state enum from shared package uart_pkg.
REQ-032 SHALL instantiate the existing serial sub-modules uart_rx and uart_tx, with rstn_i driven by ~rst_i and clk_div_i by CLK_DIV_RST.
REQ-033 SHALL fit in 120-400 lines of RTL, one FSM plus datapath.

Verification
REQ-034 SHALL cover: write 57 10 00 00 40 EF BE AD DE -> one APB write, PADDR=0x40000010, PWDATA=0xDEADBEEF; tx byte 0x4B.
REQ-035 SHALL cover: read 52 04 00 00 40, slave PRDATA=0x12345678 with 3 wait states -> PENABLE held 4 cycles; tx bytes 78 56 34 12.
REQ-036 SHALL cover: command byte 0x33 -> no PSEL; tx byte 0x45; a following valid read completes normally.
REQ-037 SHALL cover: PREADY stuck low -> PSEL drops after 1024 ACCESS cycles; tx byte 0x54.
REQ-038 SHALL cover: parity error on 3rd address byte -> no APB transfer; tx byte 0x45.
REQ-039 SHALL cover: rst_i pulsed during ACCESS -> PSEL=0 next cycle, tx_o idle high, busy_o=0.
